shift_add_mul: RTL and testbench
================================

SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk is the sole clock and reset_n is the asynchronous active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 op_start  input  1  request a new multiplication; sampled on rising clk edges.
REQ-005 op_clear  input  1  synchronous abort/clear; highest-priority command.
REQ-006 multiplicand  input  32  unsigned operand A, sampled only in the op_start acceptance cycle.
REQ-007 multiplier  input  32  unsigned operand B, sampled only in the op_start acceptance cycle.
REQ-008 result  output  64  accumulator register; holds the final product A*B while op_done=1.
REQ-009 busy  output  1  high while in EXEC.
REQ-010 op_done  output  1  high while in DONE.

Function
REQ-011 The FSM SHALL have three states: IDLE, EXEC and DONE.
REQ-012 Transitions SHALL be as follows.
- IDLE -> EXEC on op_start=1.
- EXEC -> DONE after the 32nd EXEC cycle.
- DONE -> EXEC on op_start=1.
- Any state -> IDLE on op_clear=1.
REQ-013 On op_start acceptance, the block SHALL load the registers as follows: mcand_sh[63:0]={32'b0,multiplicand}; mplier[31:0]=multiplier; acc=0; count=0.
REQ-014 In each EXEC cycle, the block SHALL perform the following updates.
- If mplier[0]=1, then acc <= acc + mcand_sh.
- mcand_sh <= mcand_sh << 1.
- mplier <= mplier >> 1.
- count <= count + 1.
REQ-015 The block SHALL use a fixed 32-cycle EXEC phase, with no early termination on a zero multiplier.
REQ-016 The addition SHALL be 64-bit unsigned with carry-in 0, and the carry-out SHALL be discarded; the 64-bit width guarantees no overflow for 32x32 operands.
REQ-017 Latency: if op_start is accepted at edge N, then op_done SHALL be 1 and result SHALL be valid from edge N+33 onward.
REQ-018 In DONE, result and op_done SHALL hold until op_clear, op_start or reset.
REQ-019 If op_start and op_clear are both 1 in the same cycle, op_clear SHALL win and the state SHALL go to IDLE.
REQ-020 op_start SHALL be ignored while in EXEC, and changes on operand inputs during EXEC SHALL have no effect.
REQ-021 op_clear SHALL zero acc, mcand_sh, mplier and count, and drive busy=0 and op_done=0 on the next edge.
REQ-022 During EXEC, result SHALL show the intermediate acc; consumers SHALL use result only when op_done=1.
REQ-023 busy and op_done SHALL be decoded from the registered state, SHALL be glitch-free and SHALL never both be 1.

Reset
REQ-024 While reset_n=0, the block SHALL hold state=IDLE, acc=0, mcand_sh=0, mplier=0, count=0, result=0, busy=0 and op_done=0, immediately and independently of clk.
REQ-025 Reset asserted mid-EXEC SHALL abandon the operation; after release, the block SHALL wait in IDLE for a fresh op_start.
REQ-026 The first op_start SHALL be honoured on the first rising edge after reset_n deasserts.

Structure
REQ-027 A shared include file mul_defs.vh SHALL hold the following:
- state encodings IDLE=2'b00, EXEC=2'b01, DONE=2'b10;
- OP_WIDTH=32;
- PROD_WIDTH=64;
- EXEC_CYCLES=32.
REQ-028 The block SHALL contain exactly one sub-module, cla64: a 64-bit carry-lookahead adder with ports a, b, ci, s, co, built from the team's 4-bit CLA cells. It SHALL be instantiated once, with ci tied to 0 and co left unused.
REQ-029 The block SHALL contain no combinational path from inputs to outputs, and all outputs SHALL be registered or decoded from registered state.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- A=5, B=3, op_start pulse -> busy high for 32 cycles, then op_done=1 with result=64'd15, held for 10 idle cycles.
- A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> result=64'hFFFF_FFFE_0000_0001 at start edge +33.
- A=0, B=32'h1234_5678 -> full 32-cycle EXEC, result=0; then A=32'h1234_5678, B=0 -> result=0.
- Start A=7, B=9; op_clear at EXEC cycle 10 -> IDLE next edge, result=0, busy=0; op_start+op_clear together -> remains IDLE.
- Start A=6, B=7, re-pulse op_start and change operands during EXEC -> ignored, result=42; op_start in DONE with A=2, B=3 -> result=6 after 33 edges.
- Assert reset_n=0 asynchronously mid-EXEC -> all outputs 0 without a clock edge; after release, IDLE until op_start.

Source files
------------

// File: rtl/shift_add_mul_pkg.sv
// Types and widths for the shift-add multiplier, derived from mul_defs.vh.
package shift_add_mul_pkg;

`include "mul_defs.vh"

    localparam int OP_WIDTH    = `MUL_OP_WIDTH;
    localparam int PROD_WIDTH  = `MUL_PROD_WIDTH;
    localparam int EXEC_CYCLES = `MUL_EXEC_CYCLES;
    localparam int CNT_WIDTH   = $clog2(EXEC_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = `MUL_ST_IDLE,
        EXEC = `MUL_ST_EXEC,
        DONE = `MUL_ST_DONE
    } state_t;

endpackage

// File: rtl/mul_defs.vh
// Shared constants for the shift-add multiplier: state encodings and datapath widths.
`ifndef MUL_DEFS_VH
`define MUL_DEFS_VH

`define MUL_ST_IDLE     2'b00
`define MUL_ST_EXEC     2'b01
`define MUL_ST_DONE     2'b10

`define MUL_OP_WIDTH    32
`define MUL_PROD_WIDTH  64
`define MUL_EXEC_CYCLES 32

`endif

// File: rtl/shift_add_mul_cla64.sv
// 64-bit carry-lookahead adder: sixteen 4-bit CLA cells, group carries chained cell to cell.
// Latency: combinational. Backpressure: none.
module cla64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        ci,
    output logic [63:0] s,
    output logic        co
);

    logic [63:0] g;
    logic [63:0] p;
    logic [16:0] gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = ci;
    assign co    = gc[16];

    for (genvar k = 0; k < 16; k++) begin : g_cell
        logic [3:0] gg;
        logic [3:0] pp;
        logic [3:0] c;
        logic       grp_g;
        logic       grp_p;

        assign gg = g[4*k +: 4];
        assign pp = p[4*k +: 4];

        assign c[0] = gc[k];
        assign c[1] = gg[0] | (pp[0] & c[0]);
        assign c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
        assign c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                    | (pp[2] & pp[1] & pp[0] & c[0]);

        // Group generate/propagate feed the next cell's carry-in.
        assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign grp_p = &pp;
        assign gc[k+1] = grp_g | (grp_p & c[0]);

        assign s[4*k +: 4] = pp ^ c;
    end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential 32x32 unsigned shift-add multiplier with IDLE/EXEC/DONE control.
// Latency: op_start accepted at edge N gives op_done and the product from edge N+33; op_start ignored in EXEC.
module shift_add_mul
    import shift_add_mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  op_start,
    input  logic                  op_clear,
    input  logic [OP_WIDTH-1:0]   multiplicand,
    input  logic [OP_WIDTH-1:0]   multiplier,
    output logic [PROD_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  op_done
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(EXEC_CYCLES);

    state_t                state;
    logic [PROD_WIDTH-1:0] acc;
    logic [PROD_WIDTH-1:0] mcand_sh;
    logic [OP_WIDTH-1:0]   mplier;
    logic [CNT_WIDTH-1:0]  count;
    logic [PROD_WIDTH-1:0] sum;
    logic                  add_co_unused;

    cla64 u_cla64 (
        .a  (acc),
        .b  (mcand_sh),
        .ci (1'b0),
        .s  (sum),
        .co (add_co_unused)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            count    <= '0;
            busy     <= 1'b0;
            op_done  <= 1'b0;
        end else if (op_clear) begin
            state    <= IDLE;
            acc      <= '0;
            mcand_sh <= '0;
            mplier   <= '0;
            count    <= '0;
            busy     <= 1'b0;
            op_done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (op_start) begin
                        state    <= EXEC;
                        acc      <= '0;
                        mcand_sh <= {{(PROD_WIDTH-OP_WIDTH){1'b0}}, multiplicand};
                        mplier   <= multiplier;
                        count    <= '0;
                        busy     <= 1'b1;
                        op_done  <= 1'b0;
                    end
                end
                EXEC: begin
                    // All 32 add/shift steps are done once count reaches 32; this cycle only hands over to DONE.
                    if (count == LAST_CNT) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        op_done <= 1'b1;
                    end else begin
                        if (mplier[0]) begin
                            acc <= sum;
                        end
                        mcand_sh <= mcand_sh << 1;
                        mplier   <= mplier >> 1;
                        count    <= count + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    op_done <= 1'b0;
                end
            endcase
        end
    end

    assign result = acc;

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed bench for shift_add_mul: product table, exact latency, hold, clear, ignore-in-EXEC and reset cases.
module tb_shift_add_mul;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_start;
    logic        op_clear;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] result;
    logic        busy;
    logic        op_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_add_mul dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .busy         (busy),
        .op_done      (op_done)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Drives op_start for one edge; returns #1 after the acceptance edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(posedge clk);
        #1;
        op_start     = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    // Counts edges since acceptance until op_done, bounded at 40.
    task automatic wait_done(input int already, output int n);
        n = already;
        while (n < 40 && op_done !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 32) begin
                chk("busy_at_edge32", {63'b0, busy}, 64'd1);
                chk("no_done_at_edge32", {63'b0, op_done}, 64'd0);
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                          input string name);
        int n;
        start_op(a, b);
        chk({name, "_busy_start"}, {62'b0, busy, op_done}, 64'd2);
        wait_done(0, n);
        chk({name, "_latency"}, 64'(n), 64'd33);
        chk({name, "_result"}, result, exp);
        chk({name, "_flags"}, {62'b0, busy, op_done}, 64'd1);
    endtask

    initial begin
        int n;

        vecs[0] = '{32'd1,          32'd1,          64'd1};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,          32'h1234_5678,  64'd0};
        vecs[3] = '{32'h1234_5678,  32'd0,          64'd0};
        vecs[4] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
        vecs[5] = '{32'h1234_5678,  32'd16,         64'h0000_0001_2345_6780};
        vecs[6] = '{32'd1000,       32'd1000,       64'd1000000};
        vecs[7] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

        reset_n      = 1'b0;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_flags", {62'b0, busy, op_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", {62'b0, busy, op_done}, 64'd0);

        // 5*3 and hold in DONE for 10 idle cycles.
        run_op(32'd5, 32'd3, 64'd15, "mul5x3");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", result, 64'd15);
            chk("hold_done", {62'b0, busy, op_done}, 64'd1);
        end

        // Table vectors, each restarted from DONE.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
        end

        // Clear after 10 EXEC edges, then start+clear together.
        start_op(32'd7, 32'd9);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("pre_clear_busy", {63'b0, busy}, 64'd1);
        @(negedge clk);
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        chk("clear_flags", {62'b0, busy, op_done}, 64'd0);
        chk("clear_result", result, 64'd0);
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        @(posedge clk);
        #1;
        chk("start_and_clear", {62'b0, busy, op_done}, 64'd0);
        op_start = 1'b0;
        op_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stays_idle", {62'b0, busy, op_done}, 64'd0);

        // Re-pulsed op_start and new operands during EXEC are ignored.
        start_op(32'd6, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op_start     = 1'b1;
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        repeat (2) @(posedge clk);
        #1;
        op_start = 1'b0;
        wait_done(6, n);
        chk("ignore_latency", 64'(n), 64'd33);
        chk("ignore_result", result, 64'd42);
        run_op(32'd2, 32'd3, 64'd6, "restart_from_done");

        // Asynchronous reset mid-EXEC.
        start_op(32'd9, 32'd9);
        repeat (15) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_result", result, 64'd0);
        chk("async_reset_flags", {62'b0, busy, op_done}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_release", {62'b0, busy, op_done}, 64'd0);
        chk("idle_after_release_result", result, 64'd0);

        // op_start honoured on the first edge after release.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n      = 1'b1;
        op_start     = 1'b1;
        multiplicand = 32'd3;
        multiplier   = 32'd4;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        chk("first_edge_start", {62'b0, busy, op_done}, 64'd2);
        wait_done(0, n);
        chk("first_edge_latency", 64'(n), 64'd33);
        chk("first_edge_result", result, 64'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
